free_list: RTL

Physical-register free list for the rename/retire loop. It consumes the ROB's two retire ports, returning each retiring instruction's previous physical mapping (`rd_old`) to a circular free pool. It supplies one free physical register per cycle to the rename stage, which writes it into the ROB as the new `rd`. It is a multi-push, single-pop circular FIFO with occupancy tracking and an overflow guard.

---
 rtl/free_list_pkg.sv | 28 ++
 rtl/free_list_if.sv | 29 ++
 rtl/free_list_fl_ram.sv | 35 +++
 rtl/free_list.sv | 87 ++++++++
 4 files changed

// File: rtl/free_list_pkg.sv
// free_list_pkg: shared constants and types for the physical-register free
// list. Also carries the ROB retire-bus field macros so every consumer of the
// retire ports slices them the same way.
//   RETIRE bus layout: {valid, rd_old[5:0], data[31:0], rd[5:0]}

`ifndef ROB_CONSTANTS_DEFINED
`define ROB_CONSTANTS_DEFINED
`define RETIRE_WIDTH 45
`define PREG_WIDTH   6
`define RETIRE_VALID 44
`define RETIRE_OLD   43:38
`define RETIRE_DATA  37:6
`define RETIRE_RD    5:0
`endif

package free_list_pkg;
    localparam int NUM_PREGS    = 64;
    localparam int NUM_AREGS    = 32;
    localparam int PREG_WIDTH   = `PREG_WIDTH;
    localparam int CNT_WIDTH    = 7;
    localparam int RETIRE_WIDTH = `RETIRE_WIDTH;
    // Pool can never hold more than the registers not architecturally mapped.
    localparam int FL_CAP       = NUM_PREGS - NUM_AREGS;

    typedef logic [PREG_WIDTH-1:0]   preg_t;
    typedef logic [CNT_WIDTH-1:0]    cnt_t;
    typedef logic [RETIRE_WIDTH-1:0] retire_t;
endpackage

// File: rtl/free_list_if.sv
// free_list_if: rename/retire side of the free list.
//   alloc_req            rename consumes alloc_preg this cycle
//   alloc_valid/preg     show-ahead head of the free pool
//   retire0/retire1      ROB retire slots (slot 1 younger)
//   free_count/empty/full/overflow_err  pool status
// slave = the free list, master = rename/ROB.
interface free_list_if;
    import free_list_pkg::*;

    logic    alloc_req;
    logic    alloc_valid;
    preg_t   alloc_preg;
    retire_t retire0;
    retire_t retire1;
    cnt_t    free_count;
    logic    empty;
    logic    full;
    logic    overflow_err;

    modport slave (
        input  alloc_req, retire0, retire1,
        output alloc_valid, alloc_preg, free_count, empty, full, overflow_err
    );

    modport master (
        output alloc_req, retire0, retire1,
        input  alloc_valid, alloc_preg, free_count, empty, full, overflow_err
    );
endinterface

// File: rtl/free_list_fl_ram.sv
// fl_ram: NUM_PREGS x PREG_WIDTH storage for the free pool.
//   clk, rst_n  clock, async active-low reset
//   we[1:0]     write enables; port 1 wins on an address collision
//   waddr/wdata per-port write address/data
//   raddr/rdata asynchronous read port (pool head)
// Reset loads slots 0..FL_CAP-1 with p(NUM_AREGS)..p(NUM_PREGS-1).
module fl_ram
    import free_list_pkg::*;
#(
    parameter int DEPTH = NUM_PREGS,
    parameter int AW    = $clog2(NUM_PREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           we,
    input  logic [1:0][AW-1:0]   waddr,
    input  logic [1:0][PREG_WIDTH-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output preg_t                rdata
);
    preg_t mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= (i < FL_CAP) ? preg_t'(i + NUM_AREGS) : '0;
        end else begin
            // Later port overrides earlier on the same slot.
            for (int p = 0; p < 2; p++)
                if (we[p]) mem[waddr[p]] <= wdata[p];
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/free_list.sv
// free_list: physical-register free pool for rename/retire.
//   clk, rst_n  clock, async active-low reset
//   bus         free_list_if.slave: single pop per cycle to rename, up to two
//               pushes per cycle from ROB retire (rd_old), status outputs.
// Circular buffer with head/tail pointers and an explicit count. Pushes that
// would exceed FL_CAP (after crediting a same-cycle pop) are dropped, youngest
// slot first, and set a sticky overflow_err.
module free_list
    import free_list_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    free_list_if.slave bus
);
    localparam int AW = $clog2(NUM_PREGS);

    logic [AW-1:0] head, tail;
    cnt_t          count;
    logic          ovf_q;

    logic          push0, push1, acc0, acc1, pop, drop;
    cnt_t          room;
    logic [1:0]    n_push;
    logic [1:0]           ram_we;
    logic [1:0][AW-1:0]   ram_waddr;
    logic [1:0][PREG_WIDTH-1:0] ram_wdata;
    preg_t         head_preg;

    // Payload and new-rd fields ride along on the retire bus but are not
    // needed here.
    logic unused_retire;
    assign unused_retire = ^{bus.retire0[`RETIRE_DATA], bus.retire0[`RETIRE_RD],
                             bus.retire1[`RETIRE_DATA], bus.retire1[`RETIRE_RD]};

    // p0 is hardwired and never returns to the pool.
    assign push0 = bus.retire0[`RETIRE_VALID] && (bus.retire0[`RETIRE_OLD] != '0);
    assign push1 = bus.retire1[`RETIRE_VALID] && (bus.retire1[`RETIRE_OLD] != '0);

    // No bypass: an empty pool cannot pop even if a push lands this cycle.
    assign pop  = bus.alloc_req && (count != '0);

    // Free space with the pop already credited; count <= FL_CAP so no wrap.
    assign room = cnt_t'(FL_CAP) - count + cnt_t'(pop);
    assign acc0 = push0 && (room != '0);
    assign acc1 = push1 && (room > cnt_t'(acc0));
    assign drop = (push0 && !acc0) || (push1 && !acc1);

    assign n_push = {1'b0, acc0} + {1'b0, acc1};

    // retire1 packs directly behind retire0, or takes tail if retire0 is idle.
    assign ram_we       = {acc1, acc0};
    assign ram_waddr[0] = tail;
    assign ram_waddr[1] = acc0 ? tail + AW'(1) : tail;
    assign ram_wdata[0] = bus.retire0[`RETIRE_OLD];
    assign ram_wdata[1] = bus.retire1[`RETIRE_OLD];

    fl_ram #(.DEPTH(NUM_PREGS), .AW(AW)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (head),
        .rdata (head_preg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= AW'(FL_CAP);
            count <= cnt_t'(FL_CAP);
            ovf_q <= 1'b0;
        end else begin
            head  <= head + AW'(pop);
            tail  <= tail + AW'(n_push);
            count <= count + cnt_t'(n_push) - cnt_t'(pop);
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign bus.alloc_valid  = (count != '0);
    assign bus.alloc_preg   = head_preg;
    assign bus.free_count   = count;
    assign bus.empty        = (count == '0);
    assign bus.full         = (count == cnt_t'(FL_CAP));
    assign bus.overflow_err = ovf_q;
endmodule
